// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import mem_arb_pkg::*;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  err_align;

  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err_align,
           mem_enable, mem_wr, mem_addr, mem_data_in
  );

  // Requester/memory side.
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err_align,
           mem_enable, mem_wr, mem_addr, mem_data_in
  );

endinterface

// File: rtl/mem_arb_fair.sv
// Fixed D-over-I priority with a saturating starvation counter that lets I win
// one contended grant after STARVE_LIMIT consecutive contended D grants.
module mem_arb_fair #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;
  logic            i_wins;

  always_comb begin
    i_wins    = (starve_q == Limit);
    grant_d_o = grant_en_i && d_req_i && !(i_req_i && i_wins);
    grant_i_o = grant_en_i && i_req_i && !grant_d_o;

    starve_d = starve_q;
    if (grant_i_o) begin
      starve_d = '0;
    end else if (grant_d_o) begin
      if (!i_req_i) begin
        starve_d = '0;
      end else if (starve_q != Limit) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle memory port between instruction fetch (I) and
// load/store (D), with programmable wait states and registered completions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus_io
);

  localparam int unsigned WaitW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(WAIT_CYCLES);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic                  i_rvalid_q, i_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  err_q, err_d;

  logic grant_en, gnt_i, gnt_d, strobe;

  assign grant_en = (state_q == ARB_IDLE);
  assign strobe   = (state_q == ARB_BUSY) && (wait_q == '0);

  mem_arb_fair #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fair (
    .clk       (clk),
    .rst       (rst),
    .grant_en_i(grant_en),
    .i_req_i   (bus_io.i_req),
    .d_req_i   (bus_io.d_req),
    .grant_i_o (gnt_i),
    .grant_d_o (gnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_I;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_i || gnt_d) begin
          state_d = ARB_BUSY;
          wait_d  = WaitLoad;
        end
      end
      ARB_BUSY: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    owner_d = owner_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (gnt_d) begin
      owner_d = OWN_D;
      addr_d  = {bus_io.d_addr[ADDR_WIDTH-1:1], 1'b0};
      wr_d    = bus_io.d_wr;
      wdata_d = bus_io.d_wdata;
    end else if (gnt_i) begin
      owner_d = OWN_I;
      addr_d  = {bus_io.i_addr[ADDR_WIDTH-1:1], 1'b0};
      wr_d    = 1'b0;
      wdata_d = '0;
    end

    err_d      = (gnt_d && bus_io.d_addr[0]) || (gnt_i && bus_io.i_addr[0]);
    i_rvalid_d = strobe && (owner_q == OWN_I);
    d_rvalid_d = strobe && (owner_q == OWN_D);
    i_rdata_d  = (strobe && (owner_q == OWN_I)) ? bus_io.mem_data_out : i_rdata_q;
    // Writes complete through d_rvalid but must leave d_rdata untouched.
    d_rdata_d  = (strobe && (owner_q == OWN_D) && !wr_q) ? bus_io.mem_data_out : d_rdata_q;
  end

  always_comb begin
    bus_io.i_gnt       = gnt_i;
    bus_io.d_gnt       = gnt_d;
    bus_io.i_rvalid    = i_rvalid_q;
    bus_io.d_rvalid    = d_rvalid_q;
    bus_io.i_rdata     = i_rdata_q;
    bus_io.d_rdata     = d_rdata_q;
    bus_io.err_align   = err_q;
    bus_io.mem_enable  = strobe;
    bus_io.mem_wr      = strobe && wr_q;
    bus_io.mem_addr    = strobe ? addr_q : '0;
    bus_io.mem_data_in = (strobe && wr_q) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiters (WAIT_CYCLES 0 and 3) each in front of a small word memory.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic mem_load;
  int   total;
  int   bad;

  mem_arbiter_if #(.ADDR_WIDTH(16)) bus0 ();
  mem_arbiter_if #(.ADDR_WIDTH(16)) bus3 ();

  mem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(0), .STARVE_LIMIT(4)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus0)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus3)
  );

  logic [15:0] mem0 [256];
  logic [15:0] mem3 [256];

  function automatic logic [15:0] pat(input int i);
    return (i == 8) ? 16'hBEEF : {8'hC0, 8'(i)};
  endfunction

  assign bus0.mem_data_out = mem0[bus0.mem_addr[8:1]];
  assign bus3.mem_data_out = mem3[bus3.mem_addr[8:1]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= pat(i);
        mem3[i] <= pat(i);
      end
    end else begin
      if (bus0.mem_enable && bus0.mem_wr) mem0[bus0.mem_addr[8:1]] <= bus0.mem_data_in;
      if (bus3.mem_enable && bus3.mem_wr) mem3[bus3.mem_addr[8:1]] <= bus3.mem_data_in;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] outs0();
    return 80'({bus0.i_gnt, bus0.i_rvalid, bus0.i_rdata, bus0.d_gnt, bus0.d_rvalid,
                bus0.d_rdata, bus0.err_align, bus0.mem_enable, bus0.mem_wr, bus0.mem_addr,
                bus0.mem_data_in});
  endfunction

  function automatic logic [79:0] outs3();
    return 80'({bus3.i_gnt, bus3.i_rvalid, bus3.i_rdata, bus3.d_gnt, bus3.d_rvalid,
                bus3.d_rdata, bus3.err_align, bus3.mem_enable, bus3.mem_wr, bus3.mem_addr,
                bus3.mem_data_in});
  endfunction

  initial begin
    logic seen;
    total = 0;
    bad   = 0;
    rst      = 1'b1;
    mem_load = 1'b1;
    bus0.i_req = 1'b0; bus0.i_addr = '0; bus0.d_req = 1'b0; bus0.d_wr = 1'b0;
    bus0.d_addr = '0; bus0.d_wdata = '0;
    bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_wr = 1'b0;
    bus3.d_addr = '0; bus3.d_wdata = '0;
    tick();
    tick();
    chk("reset_outs0", outs0(), 80'h0);
    chk("reset_outs3", outs3(), 80'h0);
    mem_load = 1'b0;
    rst      = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen = seen | bus0.mem_enable | bus3.mem_enable;
    end
    chk("idle_no_enable", 80'(seen), 80'h0);

    // I read of 0x0010 (word 8 = 0xBEEF), no wait states.
    bus0.i_req = 1'b1; bus0.i_addr = 16'h0010;
    #1;
    chk("iread_gnt", 80'({bus0.i_gnt, bus0.d_gnt}), 80'b10);
    tick();
    bus0.i_req = 1'b0;
    #1;
    chk("iread_strobe", 80'({bus0.mem_enable, bus0.mem_wr, bus0.mem_addr}), 80'({2'b10, 16'h0010}));
    tick();
    chk("iread_rvalid", 80'({bus0.i_rvalid, bus0.i_rdata}), 80'({1'b1, 16'hBEEF}));
    tick();
    chk("iread_hold", 80'({bus0.i_rvalid, bus0.i_rdata}), 80'({1'b0, 16'hBEEF}));

    // Unaligned D write 0x1234 to 0x0021.
    bus0.d_req = 1'b1; bus0.d_wr = 1'b1; bus0.d_addr = 16'h0021; bus0.d_wdata = 16'h1234;
    #1;
    chk("dwr_gnt", 80'({bus0.d_gnt, bus0.i_gnt, bus0.err_align}), 80'b100);
    tick();
    bus0.d_req = 1'b0;
    #1;
    chk("dwr_strobe", 80'({bus0.err_align, bus0.mem_enable, bus0.mem_wr, bus0.mem_addr,
                           bus0.mem_data_in}), 80'({3'b111, 16'h0020, 16'h1234}));
    tick();
    chk("dwr_done", 80'({bus0.d_rvalid, bus0.err_align, bus0.d_rdata}), 80'({2'b10, 16'h0000}));
    chk("dwr_mem", 80'(mem0[16]), 80'h1234);

    // D read back of the written word.
    bus0.d_req = 1'b1; bus0.d_wr = 1'b0; bus0.d_addr = 16'h0020;
    #1;
    chk("drd_gnt", 80'(bus0.d_gnt), 80'h1);
    tick();
    bus0.d_req = 1'b0;
    tick();
    chk("drd_data", 80'({bus0.d_rvalid, bus0.d_rdata}), 80'({1'b1, 16'h1234}));

    // Continuous contention: D,D,D,D,I repeating, nothing granted while busy.
    bus0.i_req = 1'b1; bus0.i_addr = 16'h0040;
    bus0.d_req = 1'b1; bus0.d_wr = 1'b0; bus0.d_addr = 16'h0030;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("contend_gnt%0d", k), 80'({bus0.d_gnt, bus0.i_gnt}),
          ((k % 5) == 4) ? 80'b01 : 80'b10);
      tick();
      chk($sformatf("contend_busy%0d", k), 80'({bus0.d_gnt, bus0.i_gnt}), 80'b00);
      tick();
    end
    bus0.i_req = 1'b0; bus0.d_req = 1'b0;

    // WAIT_CYCLES=3 D read at T, I request raised at T+1.
    bus3.d_req = 1'b1; bus3.d_wr = 1'b0; bus3.d_addr = 16'h0010;
    #1;
    chk("w3_dgnt", 80'(bus3.d_gnt), 80'h1);
    tick();
    bus3.d_req = 1'b0; bus3.i_req = 1'b1; bus3.i_addr = 16'h0008;
    #1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("w3_wait%0d", k), 80'({bus3.mem_enable, bus3.i_gnt}), 80'b00);
      tick();
    end
    chk("w3_strobe", 80'({bus3.mem_enable, bus3.mem_addr, bus3.i_gnt}), 80'({1'b1, 16'h0010, 1'b0}));
    tick();
    chk("w3_rvalid", 80'({bus3.d_rvalid, bus3.d_rdata, bus3.i_gnt}), 80'({1'b1, 16'hBEEF, 1'b1}));
    tick();
    bus3.i_req = 1'b0;
    tick();
    tick();
    tick();
    chk("w3_istrobe", 80'({bus3.mem_enable, bus3.mem_addr}), 80'({1'b1, 16'h0008}));
    tick();
    chk("w3_irvalid", 80'({bus3.i_rvalid, bus3.i_rdata}), 80'({1'b1, 16'hC004}));

    // Reset two cycles into a WAIT_CYCLES=3 write.
    bus3.d_req = 1'b1; bus3.d_wr = 1'b1; bus3.d_addr = 16'h0040; bus3.d_wdata = 16'h5555;
    #1;
    chk("rb_gnt", 80'(bus3.d_gnt), 80'h1);
    tick();
    bus3.d_req = 1'b0;
    #1;
    chk("rb_wait", 80'(bus3.mem_enable), 80'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rb_outs", outs3(), 80'h0);
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | bus3.mem_enable | bus3.d_rvalid;
    end
    chk("rb_quiet", 80'(seen), 80'h0);
    chk("rb_mem", 80'(mem3[32]), 80'hC020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
